// File: rtl/bcd_to_binary_if.sv
// Handshake bundle for the BCD-to-binary converter.
// The master drives start/bcd and the slave (converter) returns result, valid, busy and error.
interface bcd_to_binary_if #(
  parameter int DIGITS = 4
);
  logic                  start_i;
  logic [4*DIGITS-1:0]   bcd_i;
  logic [4*DIGITS-1:0]   out_o;
  logic                  valid_o;
  logic                  busy_o;
  logic                  error_o;

  modport master (
    output start_i, bcd_i,
    input  out_o, valid_o, busy_o, error_o
  );

  modport slave (
    input  start_i, bcd_i,
    output out_o, valid_o, busy_o, error_o
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to binary converter (reverse double-dabble) with invalid-digit detection.
// Define BCD_TO_BIN_FAST_EN to fold the subtract-3 correction into the shift state.
module bcd_to_binary #(
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  bcd_to_binary_if.slave  bus
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);

`ifdef BCD_TO_BIN_FAST_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ADJUST, DONE} state_t;
`endif

  state_t            state_q;
  logic [2*W-1:0]    shiftReg_q, shiftReg_d;
  logic [CW-1:0]     count_q, count_d;
  logic [W-1:0]      out_q;
  logic              valid_q;
  logic              error_q;

  logic [2*W-1:0]    srShifted;
  logic [W-1:0]      srShiftedAdj;
  logic [W-1:0]      srAdj;
  logic [CW-1:0]     countInc;
  logic              badDigit;

  // Digits are corrected independently; a digit >= 8 is flagged by its top bit alone.
  function automatic logic [W-1:0] subThree(input logic [W-1:0] field);
    logic [W-1:0] res;
    res = field;
    for (int k = 0; k < DIGITS; k++) begin
      if (field[4*k+3]) begin
        res[4*k +: 4] = field[4*k +: 4] - 4'd3;
      end
    end
    return res;
  endfunction

  function automatic logic hasBadDigit(input logic [W-1:0] field);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (field[4*k +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign srShifted    = shiftReg_q >> 1;
  assign srShiftedAdj = subThree(srShifted[2*W-1:W]);
  assign srAdj        = subThree(shiftReg_q[2*W-1:W]);
  assign countInc     = count_q + CW'(1);
  assign badDigit     = hasBadDigit(bus.bcd_i);

  always_comb begin
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    case (state_q)
      LOAD: begin
        if (!badDigit) begin
          shiftReg_d = {bus.bcd_i, {W{1'b0}}};
          count_d    = '0;
        end
      end
      SHIFT: begin
`ifdef BCD_TO_BIN_FAST_EN
        // The last shift lands the final binary value, so it must not be corrected.
        if (countInc == LAST) begin
          shiftReg_d = srShifted;
        end else begin
          shiftReg_d = {srShiftedAdj, srShifted[W-1:0]};
        end
`else
        shiftReg_d = srShifted;
`endif
        count_d = countInc;
      end
`ifndef BCD_TO_BIN_FAST_EN
      ADJUST: begin
        if (count_q != LAST) begin
          shiftReg_d = {srAdj, shiftReg_q[W-1:0]};
        end
      end
`endif
      DONE: begin
        shiftReg_d = '0;
        count_d    = '0;
      end
      default: begin
        shiftReg_d = shiftReg_q;
        count_d    = count_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      count_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          error_q <= badDigit;
          state_q <= badDigit ? DONE : SHIFT;
        end
        SHIFT: begin
`ifdef BCD_TO_BIN_FAST_EN
          state_q <= (countInc == LAST) ? DONE : SHIFT;
`else
          state_q <= ADJUST;
`endif
        end
`ifndef BCD_TO_BIN_FAST_EN
        ADJUST: begin
          state_q <= (count_q == LAST) ? DONE : SHIFT;
        end
`endif
        // An invalid request leaves the previous result visible alongside the error flag.
        DONE: begin
          if (!error_q) begin
            out_q <= shiftReg_q[W-1:0];
          end
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_o   = out_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.error_o = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: directed vectors push expected results, a monitor checks each Valid.
// Honours BCD_TO_BIN_FAST_EN for the expected latency.
module tb_bcd_to_binary;

`ifdef BCD_TO_BIN_FAST_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif
  localparam int PERIOD = LAT + 1;

  typedef struct {
    logic [15:0] out;
    logic        err;
    int          when;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cycle = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] lastOut = 16'h0000;
  exp_t        sb[$];
  exp_t        mon;

  bcd_to_binary_if #(.DIGITS(4)) bus();

  bcd_to_binary #(.DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every Valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("valid_unexpected", 32'(bus.valid_o), 32'd0);
      end else begin
        mon = sb.pop_front();
        checkOutput("out", 32'(bus.out_o), 32'(mon.out));
        checkOutput("error", 32'(bus.error_o), 32'(mon.err));
        checkOutput("valid_cycle", 32'(cycle), 32'(mon.when));
        checkOutput("busy_at_valid", 32'(bus.busy_o), 32'd0);
      end
    end
  end

  task automatic pushExpect(input logic [15:0] out, input logic err, input int when);
    exp_t e;
    e.out  = out;
    e.err  = err;
    e.when = when;
    sb.push_back(e);
  endtask

  // One-cycle Start pulse; t0 is the edge that samples it.
  task automatic applyStimulus(input logic [15:0] bcd, input logic [15:0] expOut,
                               input logic expErr, output int t0);
    @(negedge clk);
    bus.bcd_i   = bcd;
    bus.start_i = 1'b1;
    t0 = cycle + 1;
    if (expErr) begin
      pushExpect(lastOut, 1'b1, t0 + 2);
    end else begin
      pushExpect(expOut, 1'b0, t0 + LAT);
      lastOut = expOut;
    end
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((sb.size() != 0 || bus.busy_o === 1'b1) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      miscompares++;
      vectors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int t0;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.bcd_i   = 16'h0000;

    #12;
    checkOutput("reset_out", 32'(bus.out_o), 32'h0);
    checkOutput("reset_valid", 32'(bus.valid_o), 32'h0);
    checkOutput("reset_busy", 32'(bus.busy_o), 32'h0);
    checkOutput("reset_error", 32'(bus.error_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic conversion 1234");
    applyStimulus(16'h1234, 16'h04D2, 1'b0, t0);
    checkOutput("busy_after_t0", 32'(bus.busy_o), 32'h1);
    while (cycle < t0 + LAT - 1) @(negedge clk);
    checkOutput("busy_before_done", 32'(bus.busy_o), 32'h1);
    drain();

    $display("[TB] boundary values");
    applyStimulus(16'h9999, 16'h270F, 1'b0, t0);
    drain();
    applyStimulus(16'h0000, 16'h0000, 1'b0, t0);
    drain();
    applyStimulus(16'h0008, 16'h0008, 1'b0, t0);
    drain();

    $display("[TB] invalid digit then recovery");
    applyStimulus(16'h12A4, 16'h0000, 1'b1, t0);
    drain();
    applyStimulus(16'h0042, 16'h002A, 1'b0, t0);
    drain();

    $display("[TB] start while busy is ignored");
    applyStimulus(16'h0100, 16'h0064, 1'b0, t0);
    while (cycle < t0 + 4) @(negedge clk);
    bus.bcd_i   = 16'h5555;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    drain();

    $display("[TB] asynchronous reset mid-conversion");
    @(negedge clk);
    bus.bcd_i   = 16'h7777;
    bus.start_i = 1'b1;
    t0 = cycle + 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (cycle < t0 + 9) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_out", 32'(bus.out_o), 32'h0);
    checkOutput("abort_valid", 32'(bus.valid_o), 32'h0);
    checkOutput("abort_busy", 32'(bus.busy_o), 32'h0);
    checkOutput("abort_error", 32'(bus.error_o), 32'h0);
    lastOut = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(16'h0001, 16'h0001, 1'b0, t0);
    drain();

    $display("[TB] start held high");
    @(negedge clk);
    bus.bcd_i   = 16'h0250;
    bus.start_i = 1'b1;
    t0 = cycle + 1;
    for (int k = 0; k < 3; k++) begin
      pushExpect(16'h00FA, 1'b0, t0 + k * PERIOD + LAT);
    end
    while (cycle < t0 + 2 * PERIOD + 1) @(negedge clk);
    bus.start_i = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Multi-cycle sequential converter from packed BCD to unsigned binary, using reverse double-dabble.
- Each iteration shifts right, then subtracts 3 from every BCD digit that is >= 8.
- Counterpart of the binary-to-BCD display path: takes keypad or display-side packed BCD and returns the binary value to the datapath.
- Start-pulse / Valid-pulse handshake; Busy flag; invalid-digit detection.

Parameters:
- DIGITS, 4, number of packed BCD digits.
  - BCD input width = 4*DIGITS.
  - Binary output width = 4*DIGITS.
  - Iteration count = 4*DIGITS.

Ports:
- Clock   input   1           rising-edge system clock.
- Reset   input   1           asynchronous, active-high reset.
- Start   input   1           request; sampled only in IDLE.
- BCD     input   4*DIGITS    packed BCD; [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands (default).
- Out     output  4*DIGITS    registered binary result, zero-extended.
- Valid   output  1           one-cycle pulse when Out/Error are updated.
- Busy    output  1           high whenever state != IDLE.
- Error   output  1           high if the last accepted request had a nibble > 9; holds until the next accepted Start.

Behaviour:
- Reset (async, active-high) sets:
  - Out = 0, Valid = 0, Error = 0, Busy = 0.
  - Internal shift register = 0, iteration counter = 0, state = IDLE.
  - Reset mid-conversion aborts with no Valid pulse.
  - First Start after Reset deasserts is accepted normally.
- Internal register: SR[8*DIGITS-1:0]; upper half holds the BCD field, lower half the binary field.
- States: IDLE, LOAD, SHIFT, ADJUST, DONE.
- IDLE:
  - Valid = 0.
  - Start = 1 -> LOAD (call this edge t0).
  - Otherwise stay in IDLE.
- LOAD:
  - Clear Error.
  - If any BCD nibble > 9: set Error = 1 -> DONE; no conversion is done.
  - Else SR = {BCD, zeros}, counter = 0 -> SHIFT.
- SHIFT: SR = SR >> 1 (logical), counter += 1 -> ADJUST.
- ADJUST:
  - If counter == 4*DIGITS -> DONE.
  - Else, for every BCD-field digit >= 8, subtract 3 from it (all digits in parallel, 4-bit arithmetic, no inter-digit borrow) -> SHIFT.
- DONE:
  - Out = SR lower half; on the error path, Out keeps its old value.
  - Valid = 1 for exactly this edge's following cycle.
  - Clear SR and counter -> IDLE.
- Latency, DIGITS=4, valid input:
  - Out and Valid registered at edge t0+34 (1 LOAD + 16 SHIFT + 16 ADJUST + 1 DONE).
  - Error path: Valid and Error at t0+2.
- Start while Busy: ignored, not queued.
- Start held high across DONE: re-accepted on the first IDLE cycle. Back-to-back throughput is one conversion per 35 cycles.
- BCD is sampled only in LOAD; later changes have no effect.
- Out holds its value between conversions.
- Maximum result for 4 digits is 9999 = 16'h270F; the upper 2 bits of Out are always 0.

Optional Feature:
- Macro: BCD_TO_BIN_FAST_EN.
- Defined:
  - ADJUST state removed; SHIFT performs the shift and the >= 8 subtract-3 correction on the shifted value in the same cycle.
  - No correction after the final shift.
  - Latency for DIGITS=4 is t0+18; the error path is unchanged (t0+2).
- Undefined: two-state SHIFT/ADJUST sequencing as described above (t0+34).
- Out values are identical in both builds.

Test Plan:
- Reset, then BCD=16'h1234 with a 1-cycle Start -> Out=16'h04D2, Valid pulse at t0+34 (t0+18 with the macro), Error=0, Busy high from t0+1 to t0+34.
- BCD=16'h9999 -> Out=16'h270F. Then BCD=16'h0000 -> Out=16'h0000. Then BCD=16'h0008 -> Out=16'h0008.
- BCD=16'h12A4 -> Valid at t0+2, Error=1, Out keeps the previous value. A following Start with 16'h0042 clears Error and gives Out=16'h002A.
- Start pulsed again at t0+5 with BCD changed to 16'h5555 during a 16'h0100 conversion -> Out=16'h0064, exactly one Valid pulse.
- Reset asserted asynchronously at t0+10 during a 16'h7777 conversion -> Out, Valid, Busy and Error drop to 0 immediately, no Valid follows. A new Start with 16'h0001 gives Out=16'h0001.
- Start held high continuously with 16'h0250 -> a Valid pulse every 35 cycles (19 with the macro), Out=16'h00FA each time.
